// File: rtl/mips_mem_dump.sv
// mips_mem_dump
//   After a program run, streams a window of the byte-wide, little-endian
//   MIPS memory out as a byte stream for host-side comparison. It does the
//   reverse of the bench's hex-file memory load. Words are sent as 4 bytes in
//   ascending address order, LSB first. While busy, the block owns the memory
//   read port.
//
// Parameters
//   ADDR_W  byte-address width; the address wraps modulo 2^ADDR_W
//   CNT_W   width of word_count
//   RD_LAT  memory read latency in cycles (1..4)
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             begin a dump (sampled only while idle)
//   base_addr         first byte address, latched on an accepted start
//   word_count        number of 32-bit words, latched on an accepted start
//   busy, done        dump in progress / one-cycle end-of-dump pulse
//   mem_rd_en         one-cycle read strobe, one byte per strobe
//   mem_addr          byte address of the read
//   mem_rdata         read data, RD_LAT cycles after mem_rd_en
//   out_valid         stream byte valid
//   out_ready         sink ready; a transfer happens when valid and ready are both high
//   out_data          stream byte
//   out_last          final byte of the dump
//
// Configuration
//   DUMP_CHECKSUM_EN  when defined, the block appends a 16-bit sum of all
//                     data bytes (low byte, then high byte). In that build,
//                     out_last marks the high checksum byte.
module mips_mem_dump #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_SEND, S_TAIL, S_FIN} state_t;

    localparam logic [2:0]        LAT_LAST = 3'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W+1:0]  CNT_ONE  = {{(CNT_W+1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W+1:0]  cnt_q, cnt_d;      // bytes handed to the sink so far
    logic [CNT_W+1:0]  total_q, total_d;  // 4 * word_count, cannot overflow
    logic [2:0]        lat_q, lat_d;
    logic [7:0]        data_q, data_d;
    logic              last_byte;
`ifdef DUMP_CHECKSUM_EN
    logic [15:0]       sum_q, sum_d;
    logic              tail_q, tail_d;    // 0: low checksum byte, 1: high byte
`endif

    assign last_byte = (cnt_q == total_q - CNT_ONE);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        lat_d   = lat_q;
        data_d  = data_q;
`ifdef DUMP_CHECKSUM_EN
        sum_d   = sum_q;
        tail_d  = tail_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    cnt_d   = '0;
                    total_d = {word_count, 2'b00};
`ifdef DUMP_CHECKSUM_EN
                    sum_d   = '0;
                    tail_d  = 1'b0;
                    state_d = (word_count != '0) ? S_RD : S_TAIL;
`else
                    state_d = (word_count != '0) ? S_RD : S_FIN;
`endif
                end
            end
            S_RD: begin
                lat_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // mem_rdata is valid in the RD_LAT-th cycle after the strobe
                if (lat_q == LAT_LAST) begin
                    data_d  = mem_rdata;
                    state_d = S_SEND;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    addr_d = addr_q + ADDR_ONE;
                    cnt_d  = cnt_q + CNT_ONE;
`ifdef DUMP_CHECKSUM_EN
                    sum_d  = sum_q + {8'd0, data_q};
                    state_d = last_byte ? S_TAIL : S_RD;
`else
                    state_d = last_byte ? S_FIN : S_RD;
`endif
                end
            end
`ifdef DUMP_CHECKSUM_EN
            S_TAIL: begin
                if (out_ready) begin
                    if (tail_q) state_d = S_FIN;
                    else        tail_d  = 1'b1;
                end
            end
`endif
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            total_q <= '0;
            lat_q   <= '0;
            data_q  <= '0;
`ifdef DUMP_CHECKSUM_EN
            sum_q   <= '0;
            tail_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            lat_q   <= lat_d;
            data_q  <= data_d;
`ifdef DUMP_CHECKSUM_EN
            sum_q   <= sum_d;
            tail_q  <= tail_d;
`endif
        end
    end

    always_comb begin
        busy      = (state_q != S_IDLE) && (state_q != S_FIN);
        done      = (state_q == S_FIN);
        mem_rd_en = (state_q == S_RD);
        mem_addr  = addr_q;
        out_valid = (state_q == S_SEND);
        out_data  = data_q;
`ifdef DUMP_CHECKSUM_EN
        out_last  = (state_q == S_TAIL) && tail_q;
        if (state_q == S_TAIL) begin
            out_valid = 1'b1;
            out_data  = tail_q ? sum_q[15:8] : sum_q[7:0];
        end
`else
        out_last  = (state_q == S_SEND) && last_byte;
`endif
    end

endmodule

// File: tb/tb_mips_mem_dump.sv
`timescale 1ns/1ps
module tb_mips_mem_dump;
    localparam int RD_LAT = 1;
`ifdef DUMP_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    typedef logic [8:0]  q9_t [$];
    typedef logic [31:0] q32_t [$];
    typedef int          qi_t [$];

    logic        clk = 1'b0;
    logic        rst, start, out_ready;
    logic [31:0] base_addr, mem_addr;
    logic [15:0] word_count;
    logic        busy, done, mem_rd_en, out_valid, out_last;
    logic [7:0]  mem_rdata, out_data;

    always #5 clk = ~clk;

    mips_mem_dump #(.ADDR_W(32), .CNT_W(16), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents: explicit entries, otherwise a fixed function of the address
    logic [7:0] mem_tab [logic [31:0]];
    function automatic logic [7:0] mem_val(input logic [31:0] a);
        if (mem_tab.exists(a)) return mem_tab[a];
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    // Read port with RD_LAT latency; junk on the bus outside the valid cycle
    logic [7:0] pd [0:3];
    logic [3:0] pv = 4'd0;
    logic [7:0] junk = 8'd0;
    always @(posedge clk) begin
        pv    <= {pv[2:0], mem_rd_en};
        pd[0] <= mem_val(mem_addr);
        pd[1] <= pd[0];
        pd[2] <= pd[1];
        pd[3] <= pd[2];
        junk  <= 8'($urandom);
    end
    assign mem_rdata = pv[RD_LAT-1] ? pd[RD_LAT-1] : junk;

    // Sink: 0 = always ready, 1 = toggling, 2 = random
    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (out_ready === 1'b1) ? 1'b0 : 1'b1;
            default: out_ready = 1'($urandom);
        endcase
    end

    // Monitor, sampled mid-cycle
    q9_t  out_q;
    q32_t rd_q;
    qi_t  rd_cyc_q, vld_cyc_q, hs_cyc_q, done_cyc_q;
    int   stall_err = 0, busy_err = 0;
    logic stall_p = 1'b0;
    logic [8:0] held = 9'd0;
    always @(negedge clk) begin
        if (mem_rd_en) begin rd_q.push_back(mem_addr); rd_cyc_q.push_back(cyc); end
        if (stall_p && (out_valid !== 1'b1 || {out_last, out_data} !== held)) stall_err++;
        stall_p = 1'b0;
        if (out_valid) begin
            vld_cyc_q.push_back(cyc);
            if (out_ready) begin
                out_q.push_back({out_last, out_data});
                hs_cyc_q.push_back(cyc);
            end else begin
                stall_p = 1'b1;
                held    = {out_last, out_data};
            end
        end
        if (done) begin done_cyc_q.push_back(cyc); if (busy) busy_err++; end
        if (rst) stall_p = 1'b0;
    end

    int tests = 0, fails = 0;
    int s_ob, s_rb, s_vb, s_hb, s_db, s_se, s_be;
    int acc_cyc;
    bit tmo;
    q9_t  exp_q;
    q32_t exp_rd;

    task automatic snapshot();
        s_ob = out_q.size(); s_rb = rd_q.size(); s_vb = vld_cyc_q.size();
        s_hb = hs_cyc_q.size(); s_db = done_cyc_q.size(); s_se = stall_err; s_be = busy_err;
    endtask

    // Reference: bytes base..base+4*wc-1 in order, optional 16-bit sum tail
    function automatic void model(input logic [31:0] base, input int wc);
        logic [15:0] sum;
        int n;
        exp_q.delete(); exp_rd.delete();
        sum = 16'd0;
        n = 4 * wc;
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = mem_val(base + 32'(i));
            exp_rd.push_back(base + 32'(i));
            exp_q.push_back({(i == n - 1) && !CK, b});
            sum = sum + {8'd0, b};
        end
        if (CK) begin
            exp_q.push_back({1'b0, sum[7:0]});
            exp_q.push_back({1'b1, sum[15:8]});
        end
    endfunction

    function automatic q9_t tail9(input int from);
        q9_t r;
        for (int i = from; i < out_q.size(); i++) r.push_back(out_q[i]);
        return r;
    endfunction
    function automatic q32_t tail32(input int from);
        q32_t r;
        for (int i = from; i < rd_q.size(); i++) r.push_back(rd_q[i]);
        return r;
    endfunction
    function automatic int diff9(input q9_t a, input q9_t b);
        for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) return i;
        if (a.size() != b.size()) return (a.size() < b.size()) ? a.size() : b.size();
        return -1;
    endfunction
    function automatic int diff32(input q32_t a, input q32_t b);
        for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) return i;
        if (a.size() != b.size()) return (a.size() < b.size()) ? a.size() : b.size();
        return -1;
    endfunction
    function automatic logic [8:0] pick9(input q9_t q, input int i);
        return (i >= 0 && i < q.size()) ? q[i] : 9'h1FF;
    endfunction
    function automatic logic [31:0] pick32(input q32_t q, input int i);
        return (i >= 0 && i < q.size()) ? q[i] : 32'hDEAD_DEAD;
    endfunction

    // Drive one dump and wait for done (bounded); optionally disturb start/base/count while busy
    task automatic do_dump(input logic [31:0] base, input logic [15:0] wc, input int rmode, input bit noisy);
        ready_mode = rmode;
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; word_count = wc; acc_cyc = cyc;
        tmo = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk); #1;
            start = noisy;
            if (noisy) begin base_addr = $urandom; word_count = 16'($urandom); end
            @(negedge clk);
            if (done) begin tmo = 1'b0; break; end
        end
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++; if ({busy, done, mem_rd_en, mem_addr, out_valid, out_data, out_last} !== 45'd0) begin
            fails++; $display("FAIL reset_outputs: got %h required 0", {busy, done, mem_rd_en, mem_addr, out_valid, out_data, out_last}); end
        for (int i = 0; i < 8; i++) mem_tab[32'h10 + i] = 8'(i + 1);
        ready_mode = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 32'h10; word_count = 16'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        snapshot();
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if ({busy, done, mem_rd_en, mem_addr, out_valid, out_data, out_last} !== 45'd0) begin
            fails++; $display("FAIL midreset_outputs: got %h required 0", {busy, done, mem_rd_en, mem_addr, out_valid, out_data, out_last}); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        tests++; if (done_cyc_q.size() - s_db != 0 || busy !== 1'b0) begin
            fails++; $display("FAIL midreset_quiet: got done=%0d busy=%b required done=0 busy=0", done_cyc_q.size() - s_db, busy); end
    endtask

    task automatic test_basic();
        q9_t act; q32_t ard; int d;
        model(32'h10, 2);
        snapshot();
        do_dump(32'h10, 16'd2, 0, 1'b0);
        act = tail9(s_ob); ard = tail32(s_rb);
        tests++; if (tmo) begin fails++; $display("FAIL basic_timeout: got no done, required done"); end
        d = diff9(act, exp_q);
        tests++; if (d >= 0) begin fails++;
            $display("FAIL basic_stream: byte %0d got %03h required %03h (%0d vs %0d bytes)", d, pick9(act, d), pick9(exp_q, d), act.size(), exp_q.size()); end
        tests++; if (act.size() < 8 || act[7] !== {!CK, 8'h08}) begin fails++;
            $display("FAIL basic_byte8: got %03h required %03h", pick9(act, 7), {!CK, 8'h08}); end
        d = diff32(ard, exp_rd);
        tests++; if (d >= 0) begin fails++; $display("FAIL basic_reads: idx %0d got %h required %h", d, pick32(ard, d), pick32(exp_rd, d)); end
        tests++; if (done_cyc_q.size() - s_db != 1) begin fails++; $display("FAIL basic_done_count: got %0d required 1", done_cyc_q.size() - s_db); end
        tests++; if (rd_cyc_q.size() <= s_rb || rd_cyc_q[s_rb] != acc_cyc + 1) begin fails++;
            $display("FAIL basic_rd_latency: got cycle %0d required %0d", (rd_cyc_q.size() > s_rb) ? rd_cyc_q[s_rb] : -1, acc_cyc + 1); end
        tests++; if (vld_cyc_q.size() <= s_vb || vld_cyc_q[s_vb] != acc_cyc + 2 + RD_LAT) begin fails++;
            $display("FAIL basic_valid_latency: got cycle %0d required %0d", (vld_cyc_q.size() > s_vb) ? vld_cyc_q[s_vb] : -1, acc_cyc + 2 + RD_LAT); end
        tests++; if (done_cyc_q.size() <= s_db || hs_cyc_q.size() == 0 || done_cyc_q[s_db] != hs_cyc_q[hs_cyc_q.size() - 1] + 1) begin fails++;
            $display("FAIL basic_done_timing: got cycle %0d required one after last byte", (done_cyc_q.size() > s_db) ? done_cyc_q[s_db] : -1); end
        tests++; if (busy_err != s_be) begin fails++; $display("FAIL basic_busy_at_done: got %0d cycles with busy=1, required 0", busy_err - s_be); end
    endtask

    task automatic test_stall();
        q9_t act; int d;
        model(32'h10, 2);
        snapshot();
        do_dump(32'h10, 16'd2, 1, 1'b0);
        act = tail9(s_ob);
        d = diff9(act, exp_q);
        tests++; if (tmo || d >= 0) begin fails++;
            $display("FAIL stall_stream: byte %0d got %03h required %03h (timeout=%b)", d, pick9(act, d), pick9(exp_q, d), tmo); end
        tests++; if (stall_err != s_se) begin fails++; $display("FAIL stall_hold: got %0d unstable stall cycles, required 0", stall_err - s_se); end
        tests++; if (done_cyc_q.size() - s_db != 1) begin fails++; $display("FAIL stall_done_count: got %0d required 1", done_cyc_q.size() - s_db); end
    endtask

    task automatic test_wrap();
        q32_t ard; q32_t want; q9_t act; int d;
        want.push_back(32'hFFFF_FFFE); want.push_back(32'hFFFF_FFFF);
        want.push_back(32'h0000_0000); want.push_back(32'h0000_0001);
        model(32'hFFFF_FFFE, 1);
        snapshot();
        do_dump(32'hFFFF_FFFE, 16'd1, 0, 1'b0);
        ard = tail32(s_rb); act = tail9(s_ob);
        d = diff32(ard, want);
        tests++; if (tmo || d >= 0) begin fails++; $display("FAIL wrap_reads: idx %0d got %h required %h", d, pick32(ard, d), pick32(want, d)); end
        d = diff9(act, exp_q);
        tests++; if (d >= 0) begin fails++; $display("FAIL wrap_stream: byte %0d got %03h required %03h", d, pick9(act, d), pick9(exp_q, d)); end
    endtask

    task automatic test_zero();
        q9_t act; int d;
        model(32'h40, 0);
        snapshot();
        do_dump(32'h40, 16'd0, 0, 1'b0);
        act = tail9(s_ob);
        tests++; if (tmo || done_cyc_q.size() - s_db != 1) begin fails++;
            $display("FAIL zero_done_count: got %0d required 1", done_cyc_q.size() - s_db); end
        tests++; if (rd_q.size() != s_rb) begin fails++; $display("FAIL zero_reads: got %0d reads required 0", rd_q.size() - s_rb); end
`ifdef DUMP_CHECKSUM_EN
        d = diff9(act, exp_q);
        tests++; if (d >= 0 || act.size() != 2) begin fails++;
            $display("FAIL zero_checksum: byte %0d got %03h required %03h", d, pick9(act, d), pick9(exp_q, d)); end
`else
        d = 0;
        tests++; if (vld_cyc_q.size() != s_vb) begin fails++; $display("FAIL zero_valid: got %0d valid cycles required 0", vld_cyc_q.size() - s_vb); end
        tests++; if (done_cyc_q.size() <= s_db || done_cyc_q[s_db] != acc_cyc + 1) begin fails++;
            $display("FAIL zero_done_timing: got cycle %0d required %0d", (done_cyc_q.size() > s_db) ? done_cyc_q[s_db] : -1, acc_cyc + 1); end
`endif
    endtask

    task automatic test_checksum_ff();
        q9_t act; int d;
        for (int i = 0; i < 8; i++) mem_tab[32'h200 + i] = 8'hFF;
        model(32'h200, 2);
        snapshot();
        do_dump(32'h200, 16'd2, 2, 1'b0);
        act = tail9(s_ob);
        d = diff9(act, exp_q);
        tests++; if (tmo || d >= 0) begin fails++; $display("FAIL ff_stream: byte %0d got %03h required %03h", d, pick9(act, d), pick9(exp_q, d)); end
`ifdef DUMP_CHECKSUM_EN
        tests++; if (act.size() != 10 || act[8] !== 9'h0F8 || act[9] !== 9'h107) begin fails++;
            $display("FAIL ff_tail: got %03h,%03h required 0f8,107", pick9(act, 8), pick9(act, 9)); end
`else
        tests++; if (act.size() != 8 || act[7] !== 9'h1FF) begin fails++;
            $display("FAIL ff_last: got %03h required 1ff", pick9(act, 7)); end
`endif
    endtask

    task automatic test_random();
        q9_t act; q32_t ard; int d, wc; logic [31:0] base; bit noisy;
        for (int it = 0; it < 10; it++) begin
            base  = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            wc    = $urandom_range(0, 5);
            noisy = 1'($urandom_range(0, 1));
            model(base, wc);
            snapshot();
            do_dump(base, 16'(wc), 2, noisy);
            act = tail9(s_ob); ard = tail32(s_rb);
            d = diff9(act, exp_q);
            tests++; if (tmo || d >= 0) begin fails++;
                $display("FAIL rand%0d_stream: base %h wc %0d byte %0d got %03h required %03h", it, base, wc, d, pick9(act, d), pick9(exp_q, d)); end
            d = diff32(ard, exp_rd);
            tests++; if (d >= 0) begin fails++; $display("FAIL rand%0d_reads: idx %0d got %h required %h", it, d, pick32(ard, d), pick32(exp_rd, d)); end
            tests++; if (done_cyc_q.size() - s_db != 1) begin fails++; $display("FAIL rand%0d_done_count: got %0d required 1", it, done_cyc_q.size() - s_db); end
            tests++; if (stall_err != s_se) begin fails++; $display("FAIL rand%0d_hold: got %0d unstable stall cycles required 0", it, stall_err - s_se); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = 32'd0; word_count = 16'd0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_zero();
        test_checksum_ff();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
